bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.
- Sits directly upstream of the per-digit 7-segment decoders. It takes a binary value from a counter, keyboard scan code or ALU result, and produces packed BCD digits. Each 4-bit digit drives one decoder instance.
- Uses a start/busy/done handshake. It holds its last result until the next conversion completes.

---
 rtl/bin2bcd_pkg.sv | 27 ++
 rtl/bin2bcd_seq_adj3.sv | 12 +
 rtl/bin2bcd_seq.sv | 111 +++++++++++
 tb/tb_bin2bcd_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter and the downstream display stage.
//   state_t  : converter FSM state encoding (IDLE, SHIFT)
//   DIGIT_W  : bits per BCD digit
//   BCD_W    : packed BCD width for the default three-digit display
//   pow10()  : 10^n, used to derive the overflow threshold
package bin2bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned DIGITS_DEF = 3;
  localparam int unsigned BCD_W      = DIGIT_W * DIGITS_DEF;

  // 10^n evaluated at elaboration time; 64 bits covers any practical digit count.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_adj3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next decade.
//   d   : 4-bit BCD digit in
//   q_c : corrected digit (combinational), no carry out
module bcd_adj3 (
  input  logic [3:0] d,
  output logic [3:0] q_c
);

  assign q_c = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-and-add-3).
//   clk, rst_n : rising-edge clock, async active-low reset
//   start, bin : conversion request and value, captured together while idle
//   busy       : conversion in progress
//   done       : one-cycle pulse when bcd/ovf update
//   bcd, ovf   : packed BCD result (digit 0 = units) and overflow flag, held until next done
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [BIN_W-1:0]            bin,
  output logic                        busy,
  output logic                        done,
  output logic [DIGIT_W*DIGITS-1:0]   bcd,
  output logic                        ovf
);

  localparam int unsigned RES_W = DIGIT_W * DIGITS;
  localparam int unsigned SR_W  = RES_W + BIN_W;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  state_t            state, state_nxt;
  logic [SR_W-1:0]   sr, sr_nxt;
  logic [SR_W-1:0]   sr_adj;
  logic [SR_W-1:0]   sr_shl;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              ovf_pend, ovf_pend_nxt;
  logic              busy_nxt, done_nxt, ovf_nxt;
  logic [RES_W-1:0]  bcd_nxt;

  // Per-digit add-3 on the BCD field; the binary field passes through untouched.
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_adj3 u_adj (
      .d   (sr[BIN_W + DIGIT_W*k +: DIGIT_W]),
      .q_c (sr_adj[BIN_W + DIGIT_W*k +: DIGIT_W])
    );
  end
  assign sr_adj[BIN_W-1:0] = sr[BIN_W-1:0];

  // Carries out of the top digit fall off the end, giving bin mod 10^DIGITS.
  assign sr_shl = {sr_adj[SR_W-2:0], 1'b0};

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      sr       <= sr_nxt;
      cnt      <= cnt_nxt;
      ovf_pend <= ovf_pend_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      bcd      <= bcd_nxt;
      ovf      <= ovf_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    sr_nxt       = sr;
    cnt_nxt      = cnt;
    ovf_pend_nxt = ovf_pend;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    bcd_nxt      = bcd;
    ovf_nxt      = ovf;

    case (state)
      IDLE: begin
        if (start) begin
          sr_nxt       = {{RES_W{1'b0}}, bin};
          cnt_nxt      = CNT_W'(BIN_W - 1);
          ovf_pend_nxt = (64'(bin) > MAX_VAL);
          busy_nxt     = 1'b1;
          state_nxt    = SHIFT;
        end
      end

      SHIFT: begin
        sr_nxt = sr_shl;
        if (cnt == '0) begin
          bcd_nxt   = sr_shl[SR_W-1:BIN_W];
          ovf_nxt   = ovf_pend;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt  = cnt - CNT_W'(1);
          busy_nxt = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a three-digit instance and a two-digit
// instance for overflow, sharing clock and reset.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start3, start2;
  logic [7:0]  bin3, bin2;
  logic        busy3, done3, ovf3;
  logic        busy2, done2, ovf2;
  logic [11:0] bcd3;
  logic [7:0]  bcd2;

  int total = 0;
  int bad   = 0;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .bin(bin3),
    .busy(busy3), .done(done3), .bcd(bcd3), .ovf(ovf3)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a conversion on dut3 and wait for done; lat counts cycles after acceptance.
  task automatic conv3(input logic [7:0] v, output int lat, output int bcnt,
                       output logic both, output logic to);
    bin3 = v; start3 = 1'b1;
    step();
    start3 = 1'b0;
    lat = 0; bcnt = 0; both = 1'b0; to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (busy3) bcnt++;
      step();
      lat++;
      if (busy3 && done3) both = 1'b1;
      if (done3) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic conv2(input logic [7:0] v, output int lat, output logic to);
    bin2 = v; start2 = 1'b1;
    step();
    start2 = 1'b0;
    lat = 0; to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      lat++;
      if (done2) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start3 = 1'b0; start2 = 1'b0; bin3 = '0; bin2 = '0;
    #3;
    total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL reset_busy3 got=%b exp=0", busy3); end
    total++; if (done3 !== 1'b0) begin bad++; $display("FAIL reset_done3 got=%b exp=0", done3); end
    total++; if (bcd3 !== 12'h000) begin bad++; $display("FAIL reset_bcd3 got=%h exp=000", bcd3); end
    total++; if (ovf3 !== 1'b0) begin bad++; $display("FAIL reset_ovf3 got=%b exp=0", ovf3); end
    total++; if (bcd2 !== 8'h00 || ovf2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
      bad++; $display("FAIL reset_dut2 got bcd=%h ovf=%b busy=%b done=%b exp all 0", bcd2, ovf2, busy2, done2);
    end
    #9 rst_n = 1'b1;
    step();
    step();
    total++; if (busy3 !== 1'b0 || done3 !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy3, done3);
    end
  endtask

  task automatic test_basic();
    int lat, bc; logic both, to;
    conv3(8'd255, lat, bc, both, to);
    total++; if (to || lat != 8) begin bad++; $display("FAIL lat_255 got=%0d timeout=%b exp=8", lat, to); end
    total++; if (bc != 8) begin bad++; $display("FAIL busy_len_255 got=%0d exp=8", bc); end
    total++; if (both) begin bad++; $display("FAIL busy_done_overlap got=1 exp=0"); end
    total++; if (bcd3 !== 12'h255 || ovf3 !== 1'b0) begin
      bad++; $display("FAIL bcd_255 got=%h ovf=%b exp=255 ovf=0", bcd3, ovf3);
    end
    step();
    total++; if (done3 !== 1'b0 || bcd3 !== 12'h255) begin
      bad++; $display("FAIL done_pulse_hold got done=%b bcd=%h exp done=0 bcd=255", done3, bcd3);
    end
  endtask

  task automatic test_zero_99();
    int lat, bc; logic both, to;
    conv3(8'd0, lat, bc, both, to);
    total++; if (to || bcd3 !== 12'h000 || ovf3 !== 1'b0) begin
      bad++; $display("FAIL bcd_0 got=%h ovf=%b timeout=%b exp=000 ovf=0", bcd3, ovf3, to);
    end
    conv3(8'd99, lat, bc, both, to);
    total++; if (to || bcd3 !== 12'h099 || ovf3 !== 1'b0) begin
      bad++; $display("FAIL bcd_99 got=%h ovf=%b timeout=%b exp=099 ovf=0", bcd3, ovf3, to);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bin3 = 8'd99; start3 = 1'b1;
    step();
    bin3 = 8'd100;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      step(); lat++;
      if (done3) break;
    end
    total++; if (done3 !== 1'b1 || lat != 8 || bcd3 !== 12'h099) begin
      bad++; $display("FAIL b2b_first got lat=%0d done=%b bcd=%h exp lat=8 done=1 bcd=099", lat, done3, bcd3);
    end
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      step(); lat++;
      if (done3) break;
    end
    start3 = 1'b0;
    total++; if (done3 !== 1'b1 || lat != 9 || bcd3 !== 12'h100) begin
      bad++; $display("FAIL b2b_second got lat=%0d done=%b bcd=%h exp lat=9 done=1 bcd=100", lat, done3, bcd3);
    end
    step();
  endtask

  task automatic test_ignore_start();
    int lat, ndone;
    bin3 = 8'd42; start3 = 1'b1;
    step();
    start3 = 1'b0;
    lat = 0;
    step(); lat++;
    step(); lat++;
    bin3 = 8'd7; start3 = 1'b1;
    step(); lat++;
    start3 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done3) break;
      step(); lat++;
    end
    total++; if (done3 !== 1'b1 || lat != 8 || bcd3 !== 12'h042) begin
      bad++; $display("FAIL ignore_start got lat=%0d done=%b bcd=%h exp lat=8 done=1 bcd=042", lat, done3, bcd3);
    end
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done3 || busy3) ndone++;
    end
    total++; if (ndone != 0) begin
      bad++; $display("FAIL no_queued_conv got=%0d busy/done cycles exp=0", ndone);
    end
  endtask

  task automatic test_overflow();
    int lat; logic to;
    conv2(8'd200, lat, to);
    total++; if (to || lat != 8 || bcd2 !== 8'h00 || ovf2 !== 1'b1) begin
      bad++; $display("FAIL ovf_200 got bcd=%h ovf=%b lat=%0d exp bcd=00 ovf=1 lat=8", bcd2, ovf2, lat);
    end
    conv2(8'd57, lat, to);
    total++; if (to || bcd2 !== 8'h57 || ovf2 !== 1'b0) begin
      bad++; $display("FAIL ovf_57 got bcd=%h ovf=%b exp bcd=57 ovf=0", bcd2, ovf2);
    end
    conv2(8'd99, lat, to);
    total++; if (to || bcd2 !== 8'h99 || ovf2 !== 1'b0) begin
      bad++; $display("FAIL ovf_99 got bcd=%h ovf=%b exp bcd=99 ovf=0", bcd2, ovf2);
    end
    conv2(8'd100, lat, to);
    total++; if (to || bcd2 !== 8'h00 || ovf2 !== 1'b1) begin
      bad++; $display("FAIL ovf_100 got bcd=%h ovf=%b exp bcd=00 ovf=1", bcd2, ovf2);
    end
    conv2(8'd255, lat, to);
    total++; if (to || bcd2 !== 8'h55 || ovf2 !== 1'b1) begin
      bad++; $display("FAIL ovf_255 got bcd=%h ovf=%b exp bcd=55 ovf=1", bcd2, ovf2);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, nact; logic both, to;
    conv3(8'd9, lat, bc, both, to);
    total++; if (to || bcd3 !== 12'h009) begin
      bad++; $display("FAIL pre_reset_9 got=%h exp=009", bcd3);
    end
    bin3 = 8'd123; start3 = 1'b1;
    step();
    start3 = 1'b0;
    step(); step(); step();
    #1 rst_n = 1'b0;
    #1;
    total++; if (busy3 !== 1'b0 || done3 !== 1'b0 || bcd3 !== 12'h000 || ovf3 !== 1'b0) begin
      bad++; $display("FAIL async_reset got busy=%b done=%b bcd=%h ovf=%b exp 0 0 000 0", busy3, done3, bcd3, ovf3);
    end
    total++; if (bcd2 !== 8'h00 || ovf2 !== 1'b0) begin
      bad++; $display("FAIL async_reset_dut2 got bcd=%h ovf=%b exp 00 0", bcd2, ovf2);
    end
    #1 rst_n = 1'b1;
    nact = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done3 || busy3) nact++;
    end
    total++; if (nact != 0 || bcd3 !== 12'h000) begin
      bad++; $display("FAIL post_reset_quiet got act=%0d bcd=%h exp act=0 bcd=000", nact, bcd3);
    end
  endtask

  task automatic test_exhaustive();
    int lat, bc; logic both, to;
    logic [11:0] e;
    for (int v = 0; v < 256; v++) begin
      conv3(8'(v), lat, bc, both, to);
      e = 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
      total++;
      if (to || lat != 8 || both || bcd3 !== e || ovf3 !== 1'b0) begin
        bad++;
        $display("FAIL exh_%0d got bcd=%h ovf=%b lat=%0d exp bcd=%h ovf=0 lat=8", v, bcd3, ovf3, lat, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_99();
    test_back_to_back();
    test_ignore_start();
    test_overflow();
    test_reset_mid();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
